// File: rtl/level_meter_pkg.sv
// level_meter_pkg
// Shared definitions for the audio level meter datapath.
//   state_t    : sequencing states of the per-section level stage
//   amp_width  : amplitude width derived from the sample width
//   mid        : offset-binary midpoint for a given sample width
package level_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    UPDATE = 2'd2,
    OUT    = 2'd3
  } state_t;

  function automatic int amp_width(input int width);
    return width - 1;
  endfunction

  function automatic int unsigned mid(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/level_amplitude.sv
// level_amplitude
// Combinational conversion of an offset-binary min/max pair into a section
// amplitude: the larger excursion from the midpoint, saturated to the
// largest value representable in width-1 bits.
// Ports:
//   min_value  in  width    section minimum, offset binary
//   max_value  in  width    section maximum, offset binary
//   amp        out width-1  saturated amplitude
module level_amplitude
  import level_meter_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0]            min_value,
  input  logic [width-1:0]            max_value,
  output logic [amp_width(width)-1:0] amp
);

  localparam int AW = amp_width(width);
  localparam logic [width-1:0] MID     = width'(mid(width));
  localparam logic [width-1:0] AMP_MAX = MID - width'(1);

  // Only a full-negative excursion (min == 0) can exceed AMP_MAX.
  function automatic logic [AW-1:0] sat_amp(input logic [width-1:0] v);
    return AW'((v > AMP_MAX) ? AMP_MAX : v);
  endfunction

  logic [width-1:0] pos;
  logic [width-1:0] neg;

  always_comb begin
    pos = '0;
    neg = '0;
    if (max_value > MID) pos = max_value - MID;
    if (min_value < MID) neg = MID - min_value;
    amp = sat_amp((pos > neg) ? pos : neg);
  end

endmodule

// File: rtl/level_peak_hold.sv
// level_peak_hold
// Turns each accepted min/max pair into a section amplitude, tracks a peak
// with hold-then-decay ballistics and emits one level record per section.
// Optional clip indicator: define LEVEL_PEAK_HOLD_CLIP_EN to enable it;
// otherwise o_clip is tied low.
// Ports:
//   reset        in   async, active-high
//   clk          in   clock
//   i_valid      in   min/max pair valid
//   i_ready      out  high in IDLE only
//   i_min_value  in   section minimum, offset binary (width)
//   i_max_value  in   section maximum, offset binary (width)
//   o_valid      out  level record valid (OUT state)
//   o_ready      in   downstream accepts record
//   o_level      out  section amplitude (width-1)
//   o_peak       out  held/decayed peak (width-1)
//   o_clip       out  clip indicator
module level_peak_hold
  import level_meter_pkg::*;
#(
  parameter int width         = 16,
  parameter int hold_sections = 32,
  parameter int decay_shift   = 4
) (
  input  logic                        reset,
  input  logic                        clk,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [width-1:0]            i_min_value,
  input  logic [width-1:0]            i_max_value,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [amp_width(width)-1:0] o_level,
  output logic [amp_width(width)-1:0] o_peak,
  output logic                        o_clip
);

  localparam int AW     = amp_width(width);
  localparam int HOLD_W = $clog2(hold_sections + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(hold_sections);

  state_t state, state_nxt;

  logic [width-1:0]  min_p0;
  logic [width-1:0]  max_p0;
  logic [AW-1:0]     amp_c;
  logic [HOLD_W-1:0] hold_cnt;

  // Step is peak >> decay_shift, floored at 1 so small peaks still reach 0;
  // the result never drops below the current amplitude nor underflows.
  function automatic logic [AW-1:0] decay(input logic [AW-1:0] peak,
                                          input logic [AW-1:0] amp);
    logic [AW-1:0] step;
    logic [AW-1:0] dec;
    step = peak >> decay_shift;
    if (step == '0) step = AW'(1);
    dec = (peak > step) ? (peak - step) : '0;
    return (dec > amp) ? dec : amp;
  endfunction

  level_amplitude #(
    .width(width)
  ) u_level_amplitude (
    .min_value(min_p0),
    .max_value(max_p0),
    .amp      (amp_c)
  );

  assign i_ready = (state == IDLE);
  assign o_valid = (state == OUT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = CALC;
      CALC:    state_nxt = UPDATE;
      UPDATE:  state_nxt = OUT;
      OUT:     if (o_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture the accepted pair
  always_ff @(posedge clk) begin
    if (state == IDLE && i_valid) begin
      min_p0 <= i_min_value;
      max_p0 <= i_max_value;
    end
  end

  // Stage p1 (CALC) registers the amplitude; stage p2 (UPDATE) runs ballistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      o_level  <= '0;
      o_peak   <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CALC) o_level <= amp_c;
      if (state == UPDATE) begin
        if (o_level >= o_peak) begin
          o_peak   <= o_level;
          hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end else begin
          o_peak <= decay(o_peak, o_level);
        end
      end
    end
  end

`ifdef LEVEL_PEAK_HOLD_CLIP_EN
  logic [HOLD_W-1:0] clip_cnt;
  logic              clip_new;
  logic              clip_now;

  assign clip_now = (max_p0 == '1) || (min_p0 == '0);

  // The UPDATE of the clipping section itself must not consume a hold count,
  // so clip_new marks that section and the countdown starts on the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_clip   <= 1'b0;
      clip_cnt <= '0;
      clip_new <= 1'b0;
    end else if (state == CALC) begin
      clip_new <= clip_now;
      if (clip_now) begin
        o_clip   <= 1'b1;
        clip_cnt <= HOLD_LOAD;
      end
    end else if (state == UPDATE && !clip_new) begin
      if (clip_cnt != '0) clip_cnt <= clip_cnt - HOLD_W'(1);
      else                o_clip   <= 1'b0;
    end
  end
`else
  assign o_clip = 1'b0;
`endif

endmodule

// File: tb/tb_level_peak_hold.sv
// tb_level_peak_hold
// Table-driven directed vectors, hand-written backpressure and mid-operation
// reset sequences, and randomized sections checked against a behavioural
// model of the amplitude / hold / decay / clip rules.
module tb_level_peak_hold;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int DS = 2;
`ifdef LEVEL_PEAK_HOLD_CLIP_EN
  localparam int CLIP_ON = 1;
`else
  localparam int CLIP_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [W-1:0]  i_min_value = '0;
  logic [W-1:0]  i_max_value = '0;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [W-2:0]  o_level;
  logic [W-2:0]  o_peak;
  logic          o_clip;

  int n_checks = 0;
  int n_fail   = 0;

  level_peak_hold #(
    .width(W), .hold_sections(H), .decay_shift(DS)
  ) dut (
    .reset(reset), .clk(clk),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_min_value(i_min_value), .i_max_value(i_max_value),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_level(o_level), .o_peak(o_peak), .o_clip(o_clip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model state
  int m_peak, m_hold, m_clip, m_ccnt;

  task automatic model_reset();
    m_peak = 0; m_hold = 0; m_clip = 0; m_ccnt = 0;
  endtask

  task automatic model_step(input int mn, input int mx,
                            output int lvl, output int pk, output int cl);
    int pos, neg, step, dec;
    pos = (mx > 32768) ? mx - 32768 : 0;
    neg = (mn < 32768) ? 32768 - mn : 0;
    lvl = (pos > neg) ? pos : neg;
    if (lvl > 32767) lvl = 32767;
    if (lvl >= m_peak) begin
      m_peak = lvl; m_hold = H;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      step = m_peak / (1 << DS);
      if (step < 1) step = 1;
      dec = m_peak - step;
      if (dec < 0) dec = 0;
      m_peak = (dec > lvl) ? dec : lvl;
    end
    if (CLIP_ON != 0) begin
      if (mx == 65535 || mn == 0) begin
        m_clip = 1; m_ccnt = H;
      end else if (m_ccnt > 0) begin
        m_ccnt--;
      end else begin
        m_clip = 0;
      end
    end
    pk = m_peak;
    cl = m_clip;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " o_valid"}, 32'(o_valid), 0);
    chk({tag, " i_ready"}, 32'(i_ready), 1);
    chk({tag, " o_level"}, 32'(o_level), 0);
    chk({tag, " o_peak"},  32'(o_peak),  0);
    chk({tag, " o_clip"},  32'(o_clip),  0);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    o_ready = 1'b1;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_state("reset");
  endtask

  // One full section. Entered and left on a negative edge. When use_model is
  // 0 the supplied expectations are used; the model is always advanced.
  task automatic send(input int mn, input int mx, input int stall,
                      input int nmn, input int nmx, input bit use_model,
                      input int e_lvl, input int e_pk, input int e_cl,
                      input string tag);
    int lvl, pk, cl, waitc;
    logic [W-2:0] sl, sp;
    logic sc;
    model_step(mn, mx, lvl, pk, cl);
    if (!use_model) begin
      lvl = e_lvl; pk = e_pk; cl = e_cl;
    end
    waitc = 0;
    while (!i_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!i_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s i_ready timeout: got 0, expected 1", tag);
      return;
    end
    i_valid = 1'b1;
    i_min_value = 16'(mn);
    i_max_value = 16'(mx);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    chk({tag, " valid@N"}, 32'(o_valid), 0);
    chk({tag, " ready@N"}, 32'(i_ready), 0);
    @(negedge clk);
    chk({tag, " valid@N+1"}, 32'(o_valid), 0);
    @(negedge clk);
    chk({tag, " valid@N+2"}, 32'(o_valid), 1);
    chk({tag, " level"}, 32'(o_level), 32'(lvl));
    chk({tag, " peak"},  32'(o_peak),  32'(pk));
    chk({tag, " clip"},  32'(o_clip),  32'(cl));
    if (stall > 0) begin
      sl = o_level; sp = o_peak; sc = o_clip;
      o_ready = 1'b0;
      i_valid = 1'b1;
      i_min_value = 16'(nmn);
      i_max_value = 16'(nmx);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk({tag, " stall i_ready"}, 32'(i_ready), 0);
        chk({tag, " stall o_valid"}, 32'(o_valid), 1);
        chk({tag, " stall level"},   32'(o_level), 32'(sl));
        chk({tag, " stall peak"},    32'(o_peak),  32'(sp));
        chk({tag, " stall clip"},    32'(o_clip),  32'(sc));
      end
      o_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, " valid after hs"}, 32'(o_valid), 0);
    chk({tag, " ready after hs"}, 32'(i_ready), 1);
  endtask

  typedef struct {
    bit rst;
    int mn;
    int mx;
    int lvl;
    int pk;
    int cl;
  } vec_t;

  vec_t tbl[$];
  int   rmn[$];
  int   rmx[$];

  initial begin
    tbl.push_back('{1, 'h7000, 'h9000, 'h1000, 'h1000, 0});
    tbl.push_back('{0, 'h0000, 'hFFFF, 'h7FFF, 'h7FFF, 1});
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 'h8000, 'h8000, 0, 'h7FFF, 1});
    tbl.push_back('{0, 'h8000, 'h8000, 0, 'h6000, 0});
    tbl.push_back('{0, 'h8000, 'h8000, 0, 'h4800, 0});
    tbl.push_back('{1, 'h8000, 'h8003, 3, 3, 0});
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 'h8000, 'h8000, 0, 3, 0});
    tbl.push_back('{0, 'h8000, 'h8000, 0, 2, 0});
    tbl.push_back('{0, 'h8000, 'h8000, 0, 1, 0});
    tbl.push_back('{0, 'h8000, 'h8000, 0, 0, 0});
    tbl.push_back('{0, 'h8000, 'h8000, 0, 0, 0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_state("initial");

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].mn, tbl[i].mx, 0, 0, 0, 1'b0,
           tbl[i].lvl, tbl[i].pk, tbl[i].cl & CLIP_ON, $sformatf("vec%0d", i));
    end

    // Reset while a full-scale pair is in flight
    i_valid = 1'b1;
    i_min_value = 16'h0000;
    i_max_value = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    send('h8000, 'h8000, 0, 0, 0, 1'b0, 0, 0, 0, "after_midreset");

    // Backpressure: o_ready low for 10 cycles with the next pair already valid
    send('h7000, 'h9000, 10, 'h6000, 'hA000, 1'b1, 0, 0, 0, "bp_first");
    send('h6000, 'hA000, 0, 0, 0, 1'b1, 0, 0, 0, "bp_next");

    // Randomized sections against the model
    for (int i = 0; i < 121; i++) begin
      int mode, a, b;
      mode = $urandom_range(0, 7);
      case (mode)
        0: begin a = 0; b = $urandom_range(0, 65535); end
        1: begin a = $urandom_range(0, 65535); b = 65535; end
        2, 3: begin a = 'h8000; b = 'h8000; end
        4: begin a = 'h8000 - $urandom_range(0, 20); b = 'h8000 + $urandom_range(0, 20); end
        default: begin a = $urandom_range(0, 65535); b = $urandom_range(0, 65535); end
      endcase
      rmn.push_back(a);
      rmx.push_back(b);
    end
    for (int i = 0; i < 120; i++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      send(rmn[i], rmx[i], st, rmn[i+1], rmx[i+1], 1'b1, 0, 0, 0,
           $sformatf("rnd%0d", i));
    end
    i_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
